mem_bus_manager: RTL

Downstream stage of the memory controller. It takes a single read or write request per transaction (address, write data, byte select) and runs it as a Wishbone-style classic bus cycle to the external memory bus. It returns the read data and a done pulse, drives bus_full back to the controller while a cycle is in flight, and aborts any cycle whose ack never arrives.

---
 rtl/mem_bus_manager.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_bus_manager.sv
// Runs one controller request at a time as a Wishbone classic bus cycle. It returns the
// read data with a done pulse and aborts any cycle whose ack does not arrive in TIMEOUT cycles.
module mem_bus_manager #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   address_in,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [DATA_W/8-1:0] byte_sel,
  input  logic                read_req,
  input  logic                write_req,
  output logic                bus_full,
  output logic [DATA_W-1:0]   data_out,
  output logic                done,
  output logic                err,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic                wb_we_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack_i
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                bus_full_q, bus_full_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                cyc_q, cyc_d;
  logic                stb_q, stb_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Handshake: a request is accepted on any IDLE edge where read_req|write_req is high.
  // bus_full marks the BUSY/RESP window, and requests raised during it are not sampled.
  always_comb begin
    state_d    = state_q;
    bus_full_d = bus_full_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    data_out_d = data_out_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      IDLE: begin
        bus_full_d = 1'b0;
        if (read_req || write_req) begin
          adr_d      = address_in;
          dat_d      = data_in;
          sel_d      = byte_sel;
          we_d       = write_req & ~read_req;
          cyc_d      = 1'b1;
          stb_d      = 1'b1;
          bus_full_d = 1'b1;
          cnt_d      = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        // An ack on the expiry edge still completes the cycle normally.
        if (wb_ack_i) begin
          if (!we_q) data_out_d = wb_dat_i;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          done_d  = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          cyc_d      = 1'b0;
          stb_d      = 1'b0;
          done_d     = 1'b1;
          err_d      = 1'b1;
          data_out_d = '0;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        bus_full_d = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        bus_full_d = 1'b0;
        cyc_d      = 1'b0;
        stb_d      = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      bus_full_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      data_out_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      bus_full_q <= bus_full_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      data_out_q <= data_out_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus_full = bus_full_q;
  assign done     = done_q;
  assign err      = err_q;
  assign data_out = data_out_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;
  assign wb_we_o  = we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;

endmodule
